rr_rsp_router: RTL and testbench
================================

RR_RSP_ROUTER -- requirements
Module: rr_rsp_router

Interface
REQ-001 SHALL have parameter NumOut, default 4: number of response destinations; legal values are 2 to 64.
REQ-002 SHALL have parameter DataWidth, default 32: response payload width in bits.
REQ-003 SHALL have parameter DataType, default logic [DataWidth-1:0]: payload type, which may be overridden.
REQ-004 SHALL have parameter Depth, default 8: maximum number of outstanding tracked requests; legal values are 1 to 256.
REQ-005 SHALL have parameter IdxWidth, default max(1, $clog2(NumOut)): derived, do not override.
REQ-006 SHALL have parameter CntWidth, default $clog2(Depth+1): derived, do not override.
REQ-007 clk_i  in  1  single clock, posedge.
REQ-008 rst_i  in  1  reset, asynchronous and active-high.
REQ-009 flush_i  in  1  synchronous clear of all tracking state.
REQ-010 req_valid_i  in  1  a request was forwarded downstream this cycle (arbiter req_o & gnt_i).
REQ-011 req_idx_i  in  IdxWidth  source index of that request.
REQ-012 req_ready_o  out  1  tracker can accept an index.
REQ-013 rsp_valid_i  in  1  downstream response valid.
REQ-014 rsp_data_i  in  DataType  downstream response payload.
REQ-015 rsp_ready_o  out  1  downstream response accepted.
REQ-016 rsp_valid_o  out  NumOut  per-destination response valid.
REQ-017 rsp_data_o  out  NumOut x DataType  per-destination payload.
REQ-018 rsp_ready_i  in  NumOut  per-destination ready.
REQ-019 outstanding_o  out  CntWidth  number of tracked, unanswered requests.
REQ-020 err_o  out  1  sticky flag: a response arrived while nothing was outstanding.

Function
REQ-021 SHALL hold issued indices in an in-order FIFO of Depth entries; responses return in issue order.
REQ-022 Push SHALL occur when req_valid_i & req_ready_o; req_ready_o = (count != Depth), with no dependence on a same-cycle pop.
REQ-023 A req_valid_i while full SHALL be ignored, with no state change; the arbiter upstream SHALL be gated with req_ready_o.
REQ-024 A req_idx_i >= NumOut SHALL be pushed unchanged; the routing result for that entry is undefined.
REQ-025 head = FIFO head index when count > 0.
REQ-026 rsp_valid_o[head] = rsp_valid_i & (count > 0).
REQ-027 All other rsp_valid_o bits SHALL be 0.
REQ-028 rsp_data_o[k] SHALL equal rsp_data_i for every k (broadcast); only the valid bit is decoded.
REQ-029 rsp_ready_o = (count > 0) & rsp_ready_i[head]; it SHALL be purely combinational, so routing latency is 0 cycles.
REQ-030 Pop SHALL occur when rsp_valid_i & rsp_ready_o.
REQ-031 There is no bypass: an index pushed in cycle N SHALL route a response no earlier than cycle N+1.
REQ-032 On simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-033 Read and write pointers SHALL wrap from Depth-1 to 0; Depth SHALL NOT be required to be a power of two.
REQ-034 outstanding_o SHALL equal count, registered, in the range 0..Depth.
REQ-035 rsp_valid_i with count == 0 SHALL keep rsp_ready_o at 0, SHALL drive all rsp_valid_o to 0, and SHALL set err_o in the next cycle.
REQ-036 err_o SHALL hold until reset or flush.
REQ-037 flush_i SHALL clear pointers, count and err_o on the next edge and SHALL take priority over a push or pop in the same cycle.
REQ-038 While flush_i is asserted, the combinational outputs SHALL still reflect the current (pre-flush) state.

Reset
REQ-039 On rst_i, pointers, count and err_o SHALL clear to 0 asynchronously.
REQ-040 During reset, req_ready_o = 1, rsp_ready_o = 0, rsp_valid_o = '0 and outstanding_o = 0.
REQ-041 Reset asserted mid-operation SHALL discard all outstanding indices; responses arriving afterwards SHALL be handled per REQ-035.

Structure
REQ-042 No shared package is needed; IdxWidth and CntWidth are local derived parameters, matching the arbiter's idx_t convention.
REQ-043 The FIFO SHALL be one sub-module, idx_fifo, parameterized by Width and Depth, with full, empty and count outputs and asynchronous active-high reset.
REQ-044 Destination decode and ready select SHALL be top-level combinational logic.

Verification
REQ-045 NumOut=4, Depth=8: push idx 2,0,3 in consecutive cycles, then 3 responses with all ready -> rsp_valid_o = 0100, 0001, 1000 in order; outstanding_o goes 3,2,1,0.
REQ-046 Push 8 indices -> req_ready_o=0 and outstanding_o=8; a 9th req_valid_i is ignored; one pop -> req_ready_o=1 the next cycle.
REQ-047 Push idx 1, then rsp_valid_i with rsp_ready_i[1]=0 for 3 cycles -> rsp_ready_o=0 and rsp_valid_o=0010 held; the 4th cycle with ready -> pop, outstanding_o=0.
REQ-048 count=4 with simultaneous push and pop for 20 cycles -> outstanding_o stays at 4; indices route correctly across pointer wrap (Depth=5 also run).
REQ-049 rsp_valid_i with count=0 -> rsp_ready_o=0 and err_o=1 the next cycle, held; flush_i -> err_o=0 and outstanding_o=0.
REQ-050 Assert rst_i with 5 outstanding -> outstanding_o=0 immediately; the same response stream then flags err_o.

Source files
------------

// File: rtl/rr_rsp_router_idx_fifo.sv
// In-order FIFO of source indices for the response router.
// Depth need not be a power of two; pointers wrap explicitly at Depth-1.
module idx_fifo #(
    parameter int unsigned Width    = 2,
    parameter int unsigned Depth    = 8,
    parameter int unsigned CntWidth = $clog2(Depth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                push_i,
    input  logic [Width-1:0]    data_i,
    input  logic                pop_i,
    output logic [Width-1:0]    data_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [CntWidth-1:0] count_o
);
    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);

    logic [Width-1:0]    mem [Depth];
    logic [PtrWidth-1:0] wr_ptr, rd_ptr;
    logic [CntWidth-1:0] count;
    logic                do_push, do_pop;

    assign full_o  = (count == CntWidth'(Depth));
    assign empty_o = (count == '0);
    assign count_o = count;
    assign data_o  = mem[rd_ptr];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: an entry is only read once count covers it.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/rr_rsp_router.sv
// Routes in-order downstream responses back to the requester that issued them.
// The tracked source index at the FIFO head decodes the valid and selects the ready.
module rr_rsp_router #(
    parameter int unsigned NumOut    = 4,
    parameter int unsigned DataWidth = 32,
    parameter type         DataType  = logic [DataWidth-1:0],
    parameter int unsigned Depth     = 8,
    parameter int unsigned IdxWidth  = (NumOut > 1) ? $clog2(NumOut) : 1,
    parameter int unsigned CntWidth  = $clog2(Depth + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       req_valid_i,
    input  logic [IdxWidth-1:0]        req_idx_i,
    output logic                       req_ready_o,
    input  logic                       rsp_valid_i,
    input  DataType                    rsp_data_i,
    output logic                       rsp_ready_o,
    output logic [NumOut-1:0]          rsp_valid_o,
    output DataType [NumOut-1:0]       rsp_data_o,
    input  logic [NumOut-1:0]          rsp_ready_i,
    output logic [CntWidth-1:0]        outstanding_o,
    output logic                       err_o
);
    logic [IdxWidth-1:0] head;
    logic                full, empty;
    logic [NumOut-1:0]   head_oh;
    logic                err_q;

    idx_fifo #(
        .Width    (IdxWidth),
        .Depth    (Depth),
        .CntWidth (CntWidth)
    ) u_idx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (req_valid_i),
        .data_i  (req_idx_i),
        .pop_i   (rsp_valid_i & rsp_ready_o),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (outstanding_o)
    );

    assign req_ready_o = ~full;

    // Out-of-range head indices match no destination, so nothing is routed or accepted.
    always_comb begin
        head_oh = '0;
        for (int k = 0; k < NumOut; k++) begin
            head_oh[k] = ~empty & (head == IdxWidth'(k));
        end
    end

    assign rsp_valid_o = head_oh & {NumOut{rsp_valid_i}};
    assign rsp_ready_o = |(head_oh & rsp_ready_i);

    always_comb begin
        for (int k = 0; k < NumOut; k++) rsp_data_o[k] = rsp_data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                    err_q <= 1'b0;
        else if (flush_i)             err_q <= 1'b0;
        else if (rsp_valid_i & empty) err_q <= 1'b1;
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_rr_rsp_router.sv
// Directed bench for rr_rsp_router: a Depth=8 and a Depth=5 instance share stimulus.
module tb_rr_rsp_router;
    logic        clk = 1'b0;
    logic        rst, flush, req_valid, rsp_valid;
    logic [1:0]  req_idx;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_ready;

    logic              a_req_ready, a_rsp_ready, a_err;
    logic [3:0]        a_rsp_valid;
    logic [3:0][31:0]  a_rsp_data;
    logic [3:0]        a_out;
    logic              b_req_ready, b_rsp_ready, b_err;
    logic [3:0]        b_rsp_valid;
    logic [3:0][31:0]  b_rsp_data;
    logic [2:0]        b_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rr_rsp_router #(.NumOut(4), .DataWidth(32), .Depth(8)) dut_a (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .req_valid_i(req_valid), .req_idx_i(req_idx), .req_ready_o(a_req_ready),
        .rsp_valid_i(rsp_valid), .rsp_data_i(rsp_data), .rsp_ready_o(a_rsp_ready),
        .rsp_valid_o(a_rsp_valid), .rsp_data_o(a_rsp_data), .rsp_ready_i(rsp_ready),
        .outstanding_o(a_out), .err_o(a_err)
    );

    rr_rsp_router #(.NumOut(4), .DataWidth(32), .Depth(5)) dut_b (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .req_valid_i(req_valid), .req_idx_i(req_idx), .req_ready_o(b_req_ready),
        .rsp_valid_i(rsp_valid), .rsp_data_i(rsp_data), .rsp_ready_o(b_rsp_ready),
        .rsp_valid_o(b_rsp_valid), .rsp_data_o(b_rsp_data), .rsp_ready_i(rsp_ready),
        .outstanding_o(b_out), .err_o(b_err)
    );

    function automatic logic [3:0] oh(input int i);
        logic [3:0] one;
        one = 4'b0001;
        return one << i;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        req_valid = 0; rsp_valid = 0; flush = 1;
        cyc();
        flush = 0;
    endtask

    task automatic test_reset();
        rst = 1; flush = 0; req_valid = 0; req_idx = 0;
        rsp_valid = 1; rsp_data = 32'hdead_beef; rsp_ready = 4'hF;
        #3;
        checks++; if (a_req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", a_req_ready); end
        checks++; if (a_rsp_ready !== 1'b0) begin failures++; $display("FAIL reset_rsp_ready got=%b exp=0", a_rsp_ready); end
        checks++; if (a_rsp_valid !== 4'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0000", a_rsp_valid); end
        checks++; if (a_out !== 4'd0) begin failures++; $display("FAIL reset_outstanding got=%0d exp=0", a_out); end
        checks++; if (a_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", a_err); end
        cyc(); cyc();
        rsp_valid = 0;
        rst = 0;
        cyc();
    endtask

    task automatic test_in_order();
        logic [3:0] exp_v [3];
        exp_v[0] = 4'b0100; exp_v[1] = 4'b0001; exp_v[2] = 4'b1000;
        req_valid = 1; req_idx = 2; cyc();
        req_idx = 0; cyc();
        req_idx = 3; cyc();
        req_valid = 0;
        checks++; if (a_out !== 4'd3) begin failures++; $display("FAIL inorder_count got=%0d exp=3", a_out); end
        rsp_valid = 1; rsp_ready = 4'hF;
        for (int i = 0; i < 3; i++) begin
            rsp_data = 32'h1000_0000 + i;
            #1;
            checks++; if (a_rsp_valid !== exp_v[i]) begin failures++; $display("FAIL inorder_valid%0d got=%b exp=%b", i, a_rsp_valid, exp_v[i]); end
            checks++; if (a_rsp_ready !== 1'b1) begin failures++; $display("FAIL inorder_ready%0d got=%b exp=1", i, a_rsp_ready); end
            for (int k = 0; k < 4; k++) begin
                checks++; if (a_rsp_data[k] !== 32'h1000_0000 + i) begin failures++; $display("FAIL inorder_data%0d_%0d got=%h exp=%h", i, k, a_rsp_data[k], 32'h1000_0000 + i); end
            end
            cyc();
            checks++; if (a_out !== 4'(2 - i)) begin failures++; $display("FAIL inorder_count%0d got=%0d exp=%0d", i, a_out, 2 - i); end
        end
        rsp_valid = 0;
        do_flush();
    endtask

    task automatic test_full();
        req_valid = 1;
        for (int i = 0; i < 8; i++) begin req_idx = 2'(i); cyc(); end
        checks++; if (a_req_ready !== 1'b0) begin failures++; $display("FAIL full_req_ready got=%b exp=0", a_req_ready); end
        checks++; if (a_out !== 4'd8) begin failures++; $display("FAIL full_count got=%0d exp=8", a_out); end
        req_idx = 1; cyc();
        req_valid = 0;
        checks++; if (a_out !== 4'd8) begin failures++; $display("FAIL full_ignored got=%0d exp=8", a_out); end
        rsp_valid = 1; rsp_ready = 4'hF;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++; if (a_rsp_valid !== oh(i % 4)) begin failures++; $display("FAIL full_drain%0d got=%b exp=%b", i, a_rsp_valid, oh(i % 4)); end
            cyc();
            if (i == 0) begin
                checks++; if (a_req_ready !== 1'b1) begin failures++; $display("FAIL full_ready_after_pop got=%b exp=1", a_req_ready); end
            end
        end
        rsp_valid = 0;
        checks++; if (a_out !== 4'd0) begin failures++; $display("FAIL full_drained got=%0d exp=0", a_out); end
        do_flush();
    endtask

    task automatic test_stall();
        req_valid = 1; req_idx = 1; cyc();
        req_valid = 0;
        rsp_valid = 1; rsp_ready = 4'b1101;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (a_rsp_ready !== 1'b0) begin failures++; $display("FAIL stall_ready%0d got=%b exp=0", i, a_rsp_ready); end
            checks++; if (a_rsp_valid !== 4'b0010) begin failures++; $display("FAIL stall_valid%0d got=%b exp=0010", i, a_rsp_valid); end
            cyc();
            checks++; if (a_out !== 4'd1) begin failures++; $display("FAIL stall_count%0d got=%0d exp=1", i, a_out); end
        end
        rsp_ready = 4'hF; #1;
        checks++; if (a_rsp_ready !== 1'b1) begin failures++; $display("FAIL stall_release got=%b exp=1", a_rsp_ready); end
        cyc();
        rsp_valid = 0;
        checks++; if (a_out !== 4'd0) begin failures++; $display("FAIL stall_popped got=%0d exp=0", a_out); end
        do_flush();
    endtask

    task automatic test_no_bypass();
        req_valid = 1; req_idx = 2; rsp_valid = 1; rsp_ready = 4'hF; #1;
        checks++; if (a_rsp_valid !== 4'b0 || a_rsp_ready !== 1'b0) begin failures++; $display("FAIL bypass_same_cycle got=%b/%b exp=0000/0", a_rsp_valid, a_rsp_ready); end
        cyc();
        req_valid = 0; #1;
        checks++; if (a_rsp_valid !== 4'b0100) begin failures++; $display("FAIL bypass_next_cycle got=%b exp=0100", a_rsp_valid); end
        rsp_valid = 0;
        do_flush();
    endtask

    task automatic test_back_to_back();
        logic [1:0] q [$];
        logic [1:0] nidx;
        rsp_ready = 4'hF;
        req_valid = 1;
        for (int i = 0; i < 4; i++) begin req_idx = 2'(i + 1); q.push_back(2'(i + 1)); cyc(); end
        rsp_valid = 1;
        for (int i = 0; i < 20; i++) begin
            nidx = 2'((i * 3 + 2) % 4);
            req_idx = nidx; rsp_data = 32'(i); #1;
            checks++; if (a_rsp_valid !== oh(int'(q[0]))) begin failures++; $display("FAIL b2b_a_valid%0d got=%b exp=%b", i, a_rsp_valid, oh(int'(q[0]))); end
            checks++; if (b_rsp_valid !== oh(int'(q[0]))) begin failures++; $display("FAIL b2b_b_valid%0d got=%b exp=%b", i, b_rsp_valid, oh(int'(q[0]))); end
            cyc();
            void'(q.pop_front());
            q.push_back(nidx);
            checks++; if (a_out !== 4'd4) begin failures++; $display("FAIL b2b_a_count%0d got=%0d exp=4", i, a_out); end
            checks++; if (b_out !== 3'd4) begin failures++; $display("FAIL b2b_b_count%0d got=%0d exp=4", i, b_out); end
        end
        req_valid = 0; rsp_valid = 0;
        do_flush();
    endtask

    task automatic test_error();
        rsp_valid = 1; rsp_ready = 4'hF; #1;
        checks++; if (a_rsp_ready !== 1'b0 || a_rsp_valid !== 4'b0) begin failures++; $display("FAIL err_empty_outputs got=%b/%b exp=0/0000", a_rsp_ready, a_rsp_valid); end
        checks++; if (a_err !== 1'b0) begin failures++; $display("FAIL err_not_yet got=%b exp=0", a_err); end
        cyc();
        rsp_valid = 0;
        checks++; if (a_err !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", a_err); end
        cyc(); cyc();
        checks++; if (a_err !== 1'b1) begin failures++; $display("FAIL err_held got=%b exp=1", a_err); end
        req_valid = 1; req_idx = 3; cyc();
        req_valid = 0;
        flush = 1; rsp_valid = 1; #1;
        checks++; if (a_err !== 1'b1 || a_rsp_valid !== 4'b1000) begin failures++; $display("FAIL err_flush_preview got=%b/%b exp=1/1000", a_err, a_rsp_valid); end
        req_valid = 1;
        cyc();
        flush = 0; req_valid = 0; rsp_valid = 0;
        checks++; if (a_err !== 1'b0) begin failures++; $display("FAIL err_flushed got=%b exp=0", a_err); end
        checks++; if (a_out !== 4'd0) begin failures++; $display("FAIL err_flush_count got=%0d exp=0", a_out); end
    endtask

    task automatic test_reset_mid();
        req_valid = 1;
        for (int i = 0; i < 5; i++) begin req_idx = 2'(i); cyc(); end
        req_valid = 0;
        checks++; if (a_out !== 4'd5) begin failures++; $display("FAIL rstmid_count got=%0d exp=5", a_out); end
        #2 rst = 1; #1;
        checks++; if (a_out !== 4'd0) begin failures++; $display("FAIL rstmid_async got=%0d exp=0", a_out); end
        cyc();
        rst = 0;
        rsp_valid = 1; rsp_ready = 4'hF; #1;
        checks++; if (a_rsp_ready !== 1'b0 || a_rsp_valid !== 4'b0) begin failures++; $display("FAIL rstmid_rsp got=%b/%b exp=0/0000", a_rsp_ready, a_rsp_valid); end
        cyc();
        rsp_valid = 0;
        checks++; if (a_err !== 1'b1) begin failures++; $display("FAIL rstmid_err got=%b exp=1", a_err); end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_full();
        test_stall();
        test_no_bypass();
        test_back_to_back();
        test_error();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
